// File: rtl/pipeline_stall_controller_if.sv
// rtl/pipeline_stall_controller_if.sv - hazard/branch/memory inputs and freeze/flush controls of the stall controller
interface pipeline_stall_controller_if #(
  parameter int CNT_W = 16
);
  logic             hazard_detected;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             cnt_clear;
  logic             freeze_pc;
  logic             freeze_if_id;
  logic             flush_if_id;
  logic             flush_id_exe;
  logic             freeze_back;
  logic             mem_timeout;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output hazard_detected, branch_taken, mem_req, mem_ready, cnt_clear,
    input  freeze_pc, freeze_if_id, flush_if_id, flush_id_exe, freeze_back,
    input  mem_timeout, state, stall_cycles, flush_count
  );

  modport slave (
    input  hazard_detected, branch_taken, mem_req, mem_ready, cnt_clear,
    output freeze_pc, freeze_if_id, flush_if_id, flush_id_exe, freeze_back,
    output mem_timeout, state, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - pipeline freeze/flush sequencer with memory-wait watchdog and perf counters
module pipeline_stall_controller #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input logic                    clk,
  input logic                    rst,
  pipeline_stall_controller_if.slave bus
);

  localparam logic [1:0]  ST_RUN      = 2'b00;
  localparam logic [1:0]  ST_MEM_WAIT = 2'b01;
  localparam logic [1:0]  ST_ERROR    = 2'b10;
  localparam bit          WATCHDOG_EN = (MEM_TIMEOUT != 0);
  localparam logic [15:0] WAIT_LAST   = 16'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_nxt;
  logic [15:0]      wait_cnt_q, wait_cnt_nxt;
  logic             mem_timeout_q, timeout_set;
  logic [CNT_W-1:0] stall_cycles_q, flush_count_q;

  logic freeze_pc_c, freeze_if_id_c, flush_if_id_c, flush_id_exe_c, freeze_back_c;
  logic mem_stall;

  assign mem_stall = bus.mem_req & ~bus.mem_ready;

  always_comb begin
    freeze_pc_c    = 1'b0;
    freeze_if_id_c = 1'b0;
    flush_if_id_c  = 1'b0;
    flush_id_exe_c = 1'b0;
    freeze_back_c  = 1'b0;
    state_nxt      = state_q;
    wait_cnt_nxt   = wait_cnt_q;
    timeout_set    = 1'b0;

    case (state_q)
      ST_RUN, ST_MEM_WAIT: begin
        if ((state_q == ST_RUN && mem_stall) || (state_q == ST_MEM_WAIT && !bus.mem_ready)) begin
          freeze_pc_c    = 1'b1;
          freeze_if_id_c = 1'b1;
          freeze_back_c  = 1'b1;
          if (state_q == ST_RUN) begin
            state_nxt    = ST_MEM_WAIT;
            wait_cnt_nxt = 16'd1;
          end else if (WATCHDOG_EN && wait_cnt_q == WAIT_LAST) begin
            state_nxt   = ST_ERROR;
            timeout_set = 1'b1;
          end else if (wait_cnt_q != 16'hFFFF) begin
            wait_cnt_nxt = wait_cnt_q + 16'd1;
          end
        end else begin
          // A branch squashes the instruction in ID, so its hazard no longer matters.
          if (bus.branch_taken) begin
            flush_if_id_c  = 1'b1;
            flush_id_exe_c = 1'b1;
          end else if (bus.hazard_detected) begin
            freeze_pc_c    = 1'b1;
            freeze_if_id_c = 1'b1;
            flush_id_exe_c = 1'b1;
          end
          state_nxt    = ST_RUN;
          wait_cnt_nxt = 16'd0;
        end
      end
      ST_ERROR: begin
        freeze_pc_c    = 1'b1;
        freeze_if_id_c = 1'b1;
        freeze_back_c  = 1'b1;
      end
      default: begin
        state_nxt    = ST_RUN;
        wait_cnt_nxt = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= 16'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      wait_cnt_q <= wait_cnt_nxt;
      if (timeout_set) begin
        mem_timeout_q <= 1'b1;
      end
    end
  end

  // Counters freeze in ERROR so the values at the moment of the fault survive for inspection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else if (state_q == ST_RUN || state_q == ST_MEM_WAIT) begin
      if (bus.cnt_clear) begin
        stall_cycles_q <= '0;
        flush_count_q  <= '0;
      end else begin
        if (freeze_pc_c && stall_cycles_q != CNT_MAX) begin
          stall_cycles_q <= stall_cycles_q + 1'b1;
        end
        if (flush_if_id_c && flush_count_q != CNT_MAX) begin
          flush_count_q <= flush_count_q + 1'b1;
        end
      end
    end
  end

  assign bus.freeze_pc    = rst & freeze_pc_c;
  assign bus.freeze_if_id = rst & freeze_if_id_c;
  assign bus.flush_if_id  = rst & flush_if_id_c;
  assign bus.flush_id_exe = rst & flush_id_exe_c;
  assign bus.freeze_back  = rst & freeze_back_c;
  assign bus.mem_timeout  = mem_timeout_q;
  assign bus.state        = state_q;
  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - directed scoreboard bench for pipeline_stall_controller
module tb_pipeline_stall_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipeline_stall_controller_if #(.CNT_W(16)) if_a ();
  pipeline_stall_controller_if #(.CNT_W(4))  if_b ();

  pipeline_stall_controller #(.CNT_W(16), .MEM_TIMEOUT(64)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  pipeline_stall_controller #(.CNT_W(4),  .MEM_TIMEOUT(4))  dut_b (.clk(clk), .rst(rst), .bus(if_b));

  typedef struct packed {
    logic        sel;
    logic [4:0]  ctrl;
    logic [1:0]  st;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] m_sc, m_fc;

  localparam logic [4:0] C_IDLE  = 5'b00000;
  localparam logic [4:0] C_HAZ   = 5'b11010;
  localparam logic [4:0] C_BR    = 5'b00110;
  localparam logic [4:0] C_FRZ   = 5'b11001;
  localparam logic [1:0] S_RUN   = 2'b00;
  localparam logic [1:0] S_WAIT  = 2'b01;
  localparam logic [1:0] S_ERR   = 2'b10;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] ctrl_of(input logic sel);
    if (sel)
      return {if_b.freeze_pc, if_b.freeze_if_id, if_b.flush_if_id, if_b.flush_id_exe, if_b.freeze_back};
    return {if_a.freeze_pc, if_a.freeze_if_id, if_a.flush_if_id, if_a.flush_id_exe, if_a.freeze_back};
  endfunction

  task automatic set_in(input logic hz, input logic br, input logic mr, input logic rdy, input logic clr);
    if_a.hazard_detected = hz; if_b.hazard_detected = hz;
    if_a.branch_taken    = br; if_b.branch_taken    = br;
    if_a.mem_req         = mr; if_b.mem_req         = mr;
    if_a.mem_ready       = rdy; if_b.mem_ready      = rdy;
    if_a.cnt_clear       = clr; if_b.cnt_clear      = clr;
  endtask

  task automatic check_out();
    exp_t e;
    logic [15:0] sc, fc;
    logic [1:0]  st;
    logic        mt;
    e  = exp_q.pop_front();
    st = e.sel ? if_b.state : if_a.state;
    mt = e.sel ? if_b.mem_timeout : if_a.mem_timeout;
    sc = e.sel ? 16'(if_b.stall_cycles) : if_a.stall_cycles;
    fc = e.sel ? 16'(if_b.flush_count) : if_a.flush_count;
    chk("ctrl", 16'(ctrl_of(e.sel)), 16'(e.ctrl));
    chk("state", 16'(st), 16'(e.st));
    chk("mem_timeout", 16'(mt), 16'(e.st == S_ERR));
    chk("stall_cycles", sc, e.sc);
    chk("flush_count", fc, e.fc);
  endtask

  task automatic drive(input logic sel, input logic hz, input logic br, input logic mr,
                       input logic rdy, input logic clr, input logic [4:0] ctrl, input logic [1:0] st);
    logic [15:0] mx;
    exp_t e;
    mx = sel ? 16'd15 : 16'hFFFF;
    @(negedge clk);
    rst = 1'b1;
    set_in(hz, br, mr, rdy, clr);
    e = '{sel: sel, ctrl: ctrl, st: st, sc: m_sc, fc: m_fc};
    exp_q.push_back(e);
    #1 check_out();
    if (st != S_ERR) begin
      if (clr) begin
        m_sc = 16'd0;
        m_fc = 16'd0;
      end else begin
        if (ctrl[4] && m_sc != mx) m_sc = m_sc + 16'd1;
        if (ctrl[2] && m_fc != mx) m_fc = m_fc + 16'd1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    chk("rst_ctrl_a", 16'(ctrl_of(1'b0)), 16'd0);
    chk("rst_ctrl_b", 16'(ctrl_of(1'b1)), 16'd0);
    @(posedge clk);
    m_sc = 16'd0;
    m_fc = 16'd0;
  endtask

  initial begin
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    m_sc = 16'd0;
    m_fc = 16'd0;
    @(posedge clk);
    do_reset();

    // reset state
    drive(0, 0, 0, 0, 0, 0, C_IDLE, S_RUN);
    drive(1, 0, 0, 0, 0, 0, C_IDLE, S_RUN);

    // hazard held two cycles
    drive(0, 1, 0, 0, 0, 0, C_HAZ, S_RUN);
    drive(0, 1, 0, 0, 0, 0, C_HAZ, S_RUN);
    drive(0, 0, 0, 0, 0, 0, C_IDLE, S_RUN);
    do_reset();

    // branch wins over hazard
    drive(0, 1, 1, 0, 0, 0, C_BR, S_RUN);
    drive(0, 0, 0, 0, 0, 0, C_IDLE, S_RUN);
    // memory access completing immediately does not stall
    drive(0, 0, 0, 1, 1, 0, C_IDLE, S_RUN);
    drive(0, 0, 0, 0, 0, 0, C_IDLE, S_RUN);
    do_reset();

    // three-cycle memory wait
    drive(0, 0, 0, 1, 0, 0, C_FRZ, S_RUN);
    drive(0, 0, 0, 1, 0, 0, C_FRZ, S_WAIT);
    drive(0, 0, 0, 1, 0, 0, C_FRZ, S_WAIT);
    drive(0, 0, 0, 1, 1, 0, C_IDLE, S_WAIT);
    drive(0, 0, 0, 0, 0, 0, C_IDLE, S_RUN);
    do_reset();

    // branch held through a memory wait applies on the ready cycle only
    drive(0, 0, 1, 1, 0, 0, C_FRZ, S_RUN);
    drive(0, 1, 1, 1, 0, 0, C_FRZ, S_WAIT);
    drive(0, 1, 1, 1, 1, 0, C_BR, S_WAIT);
    drive(0, 0, 0, 0, 0, 0, C_IDLE, S_RUN);
    // hazard on the ready cycle of a wait
    drive(0, 0, 0, 1, 0, 0, C_FRZ, S_RUN);
    drive(0, 1, 0, 1, 1, 0, C_HAZ, S_WAIT);
    drive(0, 0, 0, 0, 0, 0, C_IDLE, S_RUN);
    do_reset();

    // watchdog with MEM_TIMEOUT=4
    drive(1, 0, 0, 1, 0, 0, C_FRZ, S_RUN);
    drive(1, 0, 0, 1, 0, 0, C_FRZ, S_WAIT);
    drive(1, 0, 0, 1, 0, 0, C_FRZ, S_WAIT);
    drive(1, 0, 0, 1, 0, 0, C_FRZ, S_WAIT);
    drive(1, 0, 0, 1, 0, 0, C_FRZ, S_ERR);
    drive(1, 1, 1, 1, 1, 0, C_FRZ, S_ERR);
    drive(1, 0, 0, 0, 1, 1, C_FRZ, S_ERR);
    do_reset();
    drive(1, 0, 0, 0, 0, 0, C_IDLE, S_RUN);
    do_reset();

    // stall counter saturation at CNT_W=4, then clear with a concurrent hazard
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 0, 0, 0, 0, C_HAZ, S_RUN);
    end
    drive(1, 1, 0, 0, 0, 1, C_HAZ, S_RUN);
    drive(1, 0, 1, 0, 0, 0, C_BR, S_RUN);
    drive(1, 0, 0, 0, 0, 0, C_IDLE, S_RUN);

    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage ARM pipeline.
- Combines three inputs into per-register freeze/flush controls:
  - the ID-stage hazard-detect result;
  - the EXE-stage branch-taken signal;
  - the MEM-stage memory handshake (multi-cycle SRAM wait).
- Tracks memory waits with a state machine and a timeout watchdog, and keeps stall/flush performance counters readable by the testbench.

Parameters:
- CNT_W, 16, width of stall_cycles and flush_count (saturating counters).
- MEM_TIMEOUT, 64, maximum consecutive memory-stall cycles before ERROR. 0 disables the watchdog. Legal nonzero range 2..65535.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- hazard_detected  input  1  from ID hazard detection; RAW stall request.
- branch_taken  input  1  B instruction resolved taken in EXE.
- mem_req  input  1  MEM stage holds a load/store (MEM_R_EN | MEM_W_EN).
- mem_ready  input  1  memory completes the access this cycle.
- cnt_clear  input  1  zero both performance counters.
- freeze_pc  output  1  hold PC.
- freeze_if_id  output  1  hold IF/ID register.
- flush_if_id  output  1  clear IF/ID to NOP.
- flush_id_exe  output  1  clear ID/EXE to bubble.
- freeze_back  output  1  hold ID/EXE, EXE/MEM and MEM/WB registers.
- mem_timeout  output  1  sticky watchdog error.
- state  output  2  00 RUN, 01 MEM_WAIT, 10 ERROR.
- stall_cycles  output  CNT_W  cycles with freeze_pc=1.
- flush_count  output  CNT_W  taken-branch flush events.

Behaviour:
- Control outputs are combinational from state and inputs, effective in the same cycle. Counters, state, wait counter and mem_timeout are registered.
- Reset (rst=0 at an edge):
  - state=RUN, stall_cycles=0, flush_count=0, mem_timeout=0, internal wait_cnt (16b)=0.
  - While rst=0, all five control outputs are forced to 0.
- RUN, evaluated in priority order:
  1. mem_req & !mem_ready:
     - freeze_pc=freeze_if_id=freeze_back=1, flushes 0.
     - Next state MEM_WAIT, wait_cnt<=1.
  2. branch_taken:
     - flush_if_id=flush_id_exe=1, all freezes 0.
     - hazard_detected is ignored; the instruction in ID is squashed.
     - flush_count increments.
  3. hazard_detected:
     - freeze_pc=freeze_if_id=1, flush_id_exe=1 (bubble insert), freeze_back=0.
  4. Otherwise all control outputs are 0.
  - mem_req & mem_ready in the same cycle causes no stall.
- MEM_WAIT:
  - mem_ready=1:
    - Outputs follow RUN priorities 2-4 (branch, hazard, idle).
    - Next state RUN.
    - branch_taken held stable during the wait is applied only in this cycle.
  - mem_ready=0:
    - freeze_pc=freeze_if_id=freeze_back=1, flushes 0. Branch and hazard are ignored.
    - If MEM_TIMEOUT!=0 and wait_cnt==MEM_TIMEOUT-1: next state ERROR, mem_timeout<=1.
    - Otherwise wait_cnt++.
  - Total stall before ERROR is therefore exactly MEM_TIMEOUT cycles, counting the RUN detection cycle.
- ERROR:
  - All freezes 1, flushes 0.
  - All inputs are ignored and counters hold.
  - Exit only via reset.
- stall_cycles increments on every cycle with freeze_pc=1 in RUN or MEM_WAIT.
- Both counters saturate at all-ones; there is no wrap.
- cnt_clear=1 zeroes both counters at the next edge. Clear takes priority over a same-cycle increment.
- Reset mid-MEM_WAIT: the next cycle is RUN with wait_cnt=0, and any pending branch is lost. This is the required behaviour.

Test Plan:
- Hazard held 2 cycles, no mem_req -> both cycles show freeze_pc=freeze_if_id=flush_id_exe=1, freeze_back=0. stall_cycles=2 afterwards, state stays 00.
- branch_taken=1 and hazard_detected=1 in the same cycle -> flush_if_id=flush_id_exe=1, freeze_pc=0. flush_count=1, stall_cycles=0.
- mem_req=1, mem_ready=0 for cycles 0-2, mem_ready=1 at cycle 3 ->
  - freeze_back=1 in cycles 0-2 and 0 in cycle 3;
  - state=01 in cycles 1-3, 00 at cycle 4;
  - stall_cycles=3.
- branch_taken held through the mem wait, mem_ready at cycle 2 -> no flush in cycles 0-1, flush_if_id=flush_id_exe=1 in cycle 2, flush_count=1.
- MEM_TIMEOUT=4, mem_ready never asserted -> freezes in cycles 0-3; state=10 and mem_timeout=1 from cycle 4. Both persist after mem_ready=1. Reset returns state 00 and mem_timeout 0.
- CNT_W=4, 20 hazard cycles -> stall_cycles=15 (saturated). cnt_clear together with hazard -> stall_cycles=0 at the next edge.
